// File: rtl/particle_init_stream_pkg.sv
// Shared definitions for the particle initialisation stream and its helpers.
package particle_init_stream_pkg;

  localparam int unsigned PWIDTH  = 8;
  localparam int unsigned MUWIDTH = 14;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    MODE_GRID   = 2'd0,
    MODE_JITTER = 2'd1,
    MODE_RANDOM = 2'd2,
    MODE_RSVD   = 2'd3
  } init_mode_e;

  typedef struct packed {
    logic [PWIDTH-1:0]  y;
    logic [PWIDTH-1:0]  x;
    logic [MUWIDTH-1:0] mu;
  } particle_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/particle_init_stream_if.sv
// AXI-Stream style particle bus.
interface particle_init_stream_if;
  import particle_init_stream_pkg::*;

  logic      m_tvalid;
  logic      m_tready;
  logic      m_tlast;
  particle_t m_tdata;

  modport master (output m_tvalid, output m_tlast, output m_tdata, input m_tready);
  modport slave  (input m_tvalid, input m_tlast, input m_tdata, output m_tready);

endinterface

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous load and single-step advance.
module lfsr32
  import particle_init_stream_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'hACE1_ACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        advance,
  output logic [31:0] state
);

  // Load has priority over advance; otherwise the state holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= load_val;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/particle_init_stream.sv
// Generates NX*NY initial particles (grid, jittered grid or random) on a stream bus.
module particle_init_stream
  import particle_init_stream_pkg::*;
#(
  parameter int unsigned NX           = 128,
  parameter int unsigned NY           = 128,
  parameter logic [31:0] DEFAULT_SEED = 32'hACE1_ACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  init_mode_e             mode,
  input  logic [MUWIDTH-1:0]     mu_init,
  input  logic [31:0]            seed,
  output logic                   busy,
  output logic                   done,
  particle_init_stream_if.master m
);

  localparam int unsigned XW     = $clog2(NX);
  localparam int unsigned YW     = $clog2(NY);
  localparam int unsigned STEP_X = (1 << PWIDTH) / NX;
  localparam int unsigned STEP_Y = (1 << PWIDTH) / NY;

  localparam logic [PWIDTH-1:0] STEP_XV = PWIDTH'(STEP_X);
  localparam logic [PWIDTH-1:0] STEP_YV = PWIDTH'(STEP_Y);
  localparam logic [PWIDTH-1:0] MASK_X  = PWIDTH'(STEP_X - 1);
  localparam logic [PWIDTH-1:0] MASK_Y  = PWIDTH'(STEP_Y - 1);
  localparam logic [XW-1:0]     X_MAX   = XW'(NX - 1);
  localparam logic [YW-1:0]     Y_MAX   = YW'(NY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state;
  init_mode_e         mode_q;
  logic [MUWIDTH-1:0] mu_q;
  logic [XW-1:0]      x_count;
  logic [YW-1:0]      y_count;
  logic [PWIDTH-1:0]  gx;
  logic [PWIDTH-1:0]  gy;
  logic [31:0]        lfsr_q;

  logic               hs;
  logic               x_last;
  logic               final_hs;
  logic [XW-1:0]      nxt_x_count;
  logic [YW-1:0]      nxt_y_count;
  logic [PWIDTH-1:0]  nxt_gx;
  logic [PWIDTH-1:0]  nxt_gy;
  logic               nxt_is_last;
  logic [31:0]        seed_eff;
  logic [31:0]        start_rnd;
  logic [31:0]        run_rnd;
  logic               lfsr_load;
  logic [31:0]        lfsr_load_val;
  logic               lfsr_adv;

  // Build one particle from its grid cell origin and a random word.
  function automatic particle_t make_particle(
    input init_mode_e         md,
    input logic [PWIDTH-1:0]  cx,
    input logic [PWIDTH-1:0]  cy,
    input logic [31:0]        rnd,
    input logic [MUWIDTH-1:0] mu
  );
    particle_t p;
    p.mu = mu;
    case (md)
      MODE_JITTER: begin
        p.x = cx | (rnd[PWIDTH-1:0] & MASK_X);
        p.y = cy | (rnd[31:32-PWIDTH] & MASK_Y);
      end
      MODE_RANDOM: begin
        p.x = rnd[PWIDTH-1:0];
        p.y = rnd[31:32-PWIDTH];
      end
      default: begin
        p.x = cx;
        p.y = cy;
      end
    endcase
    return p;
  endfunction

  // Next-index bookkeeping and random words for the particle being loaded.
  always_comb begin
    hs          = m.m_tvalid && m.m_tready;
    x_last      = (x_count == X_MAX);
    final_hs    = hs && x_last && (y_count == Y_MAX);
    nxt_x_count = x_last ? '0 : x_count + XW'(1);
    nxt_gx      = x_last ? '0 : gx + STEP_XV;
    nxt_y_count = x_last ? y_count + YW'(1) : y_count;
    nxt_gy      = x_last ? gy + STEP_YV : gy;
    nxt_is_last = (nxt_x_count == X_MAX) && (nxt_y_count == Y_MAX);
    seed_eff    = (seed == 32'h0) ? DEFAULT_SEED : seed;
    start_rnd   = lfsr_next(seed_eff);
    run_rnd     = lfsr_next(lfsr_next(lfsr_q));
  end

  // One step on the handshake plus one for the load gives every particle a fresh word.
  always_comb begin
    lfsr_load     = 1'b0;
    lfsr_load_val = run_rnd;
    lfsr_adv      = 1'b0;
    if (state == ST_IDLE && start) begin
      lfsr_load     = 1'b1;
      lfsr_load_val = start_rnd;
    end else if (state == ST_RUN && hs) begin
      if (final_hs) begin
        lfsr_adv  = 1'b1;
      end else begin
        lfsr_load = 1'b1;
      end
    end
  end

  lfsr32 #(
    .RESET_VAL (DEFAULT_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .advance  (lfsr_adv),
    .state    (lfsr_q)
  );

  // Control FSM, position accumulators and the registered stream output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_GRID;
      mu_q       <= '0;
      x_count    <= '0;
      y_count    <= '0;
      gx         <= '0;
      gy         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      m.m_tvalid <= 1'b0;
      m.m_tlast  <= 1'b0;
      m.m_tdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= ST_RUN;
            mode_q     <= mode;
            mu_q       <= mu_init;
            x_count    <= '0;
            y_count    <= '0;
            gx         <= '0;
            gy         <= '0;
            busy       <= 1'b1;
            m.m_tvalid <= 1'b1;
            m.m_tlast  <= 1'b0;
            m.m_tdata  <= make_particle(mode, '0, '0, start_rnd, mu_init);
          end
        end
        ST_RUN: begin
          if (hs) begin
            if (final_hs) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              m.m_tvalid <= 1'b0;
              m.m_tlast  <= 1'b0;
            end else begin
              x_count   <= nxt_x_count;
              y_count   <= nxt_y_count;
              gx        <= nxt_gx;
              gy        <= nxt_gy;
              m.m_tlast <= nxt_is_last;
              m.m_tdata <= make_particle(mode_q, nxt_gx, nxt_gy, run_rnd, mu_q);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          m.m_tvalid <= 1'b0;
          m.m_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_particle_init_stream.sv
// Directed/randomised checks of particle_init_stream against a sequence model.
module tb_particle_init_stream;
  import particle_init_stream_pkg::*;

  localparam int unsigned NX = 4;
  localparam int unsigned NY = 4;
  localparam int unsigned NP = NX * NY;
  localparam int unsigned STEP = 256 / NX;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  init_mode_e         mode;
  logic [MUWIDTH-1:0] mu_init;
  logic [31:0]        seed;
  logic               busy;
  logic               done;

  particle_init_stream_if intf ();

  particle_init_stream #(
    .NX           (NX),
    .NY           (NY),
    .DEFAULT_SEED (32'hACE1_ACE1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .mu_init (mu_init),
    .seed    (seed),
    .busy    (busy),
    .done    (done),
    .m       (intf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  particle_t exp_q[$];
  particle_t got[$];
  particle_t jit_a[$], jit_b[$], rnd_z[$], rnd_d[$], rnd_1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Particle k draws the (2k+1)-th LFSR word after the effective seed.
  function automatic void build_expected(input init_mode_e md, input logic [MUWIDTH-1:0] mu,
                                         input logic [31:0] sd);
    logic [31:0] s;
    logic [7:0]  gx, gy, lo, hi;
    particle_t   p;
    s = (sd == 32'h0) ? 32'hACE1_ACE1 : sd;
    exp_q.delete();
    for (int k = 0; k < int'(NP); k++) begin
      s  = ref_step(s);
      gx = 8'((k % int'(NX)) * int'(STEP));
      gy = 8'((k / int'(NX)) * int'(STEP));
      lo = s[7:0];
      hi = s[31:24];
      p.mu = mu;
      if (md == MODE_JITTER) begin
        p.x = gx + (lo % 8'(STEP));
        p.y = gy + (hi % 8'(STEP));
      end else if (md == MODE_RANDOM) begin
        p.x = lo;
        p.y = hi;
      end else begin
        p.x = gx;
        p.y = gy;
      end
      exp_q.push_back(p);
      s = ref_step(s);
    end
  endfunction

  // Start a run and consume it, checking every handshake and stall.
  task automatic run_stream(input init_mode_e md, input logic [MUWIDTH-1:0] mu,
                            input logic [31:0] sd, input bit rand_ready,
                            input int glitch_at, input bit start_in_done);
    int        idx = 0;
    int        cycles = 0;
    int        busy_cnt = 0;
    bit        stalled = 0;
    bit        glitched = 0;
    logic      rdy;
    particle_t held;
    logic      held_last = 1'b0;
    build_expected(md, mu, sd);
    got.delete();
    held    = '0;
    mode    = md;
    mu_init = mu;
    seed    = sd;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", 64'(intf.m_tvalid), 64'd1);
    while (idx < int'(NP) && cycles < 400) begin
      if (busy) busy_cnt++;
      chk("valid_in_run", 64'(intf.m_tvalid), 64'd1);
      chk("busy_in_run", 64'(busy), 64'd1);
      if (stalled) begin
        chk("hold_data", 64'(intf.m_tdata), 64'(held));
        chk("hold_last", 64'(intf.m_tlast), 64'(held_last));
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      intf.m_tready = rdy;
      if (idx == glitch_at && !glitched) begin
        start    = 1'b1;
        mode     = MODE_RANDOM;
        glitched = 1;
      end else begin
        start = 1'b0;
      end
      if (rdy) begin
        got.push_back(intf.m_tdata);
        chk($sformatf("data[%0d]", idx), 64'(intf.m_tdata), 64'(exp_q[idx]));
        chk($sformatf("last[%0d]", idx), 64'(intf.m_tlast), 64'(idx == int'(NP) - 1));
        idx++;
        stalled = 0;
      end else begin
        stalled   = 1;
        held      = intf.m_tdata;
        held_last = intf.m_tlast;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (cycles >= 400) chk("run_timeout", 64'd0, 64'd1);
    chk("done_pulse", 64'(done), 64'd1);
    chk("valid_after", 64'(intf.m_tvalid), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("last_after", 64'(intf.m_tlast), 64'd0);
    if (!rand_ready) chk("busy_cycles", 64'(busy_cnt), 64'(NP));
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_single", 64'(done), 64'd0);
    chk("idle_valid", 64'(intf.m_tvalid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    if (start_in_done) begin
      @(negedge clk);
      chk("start_in_done_ignored", 64'(intf.m_tvalid), 64'd0);
    end
  endtask

  initial begin
    int diff;
    rst           = 1'b1;
    start         = 1'b0;
    mode          = MODE_GRID;
    mu_init       = '0;
    seed          = 32'h0;
    intf.m_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(intf.m_tvalid), 64'd0);
    chk("rst_last", 64'(intf.m_tlast), 64'd0);
    chk("rst_data", 64'(intf.m_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Grid, full throughput
    run_stream(MODE_GRID, 14'h0800, 32'h0, 1'b0, -1, 1'b0);
    chk("grid_k5_x", 64'(got[5].x), 64'd64);
    chk("grid_k5_y", 64'(got[5].y), 64'd64);
    chk("grid_k15_x", 64'(got[15].x), 64'd192);
    chk("grid_k15_y", 64'(got[15].y), 64'd192);

    // Grid with random backpressure
    run_stream(MODE_GRID, 14'h0800, 32'h0, 1'b1, -1, 1'b0);
    chk("stall_count", 64'(got.size()), 64'(NP));

    // Jitter: cell membership and repeatability
    run_stream(MODE_JITTER, 14'h1abc, 32'h1234_5678, 1'b1, -1, 1'b0);
    jit_a = got;
    for (int k = 0; k < int'(NP); k++) begin
      chk($sformatf("jit_cell_x[%0d]", k), 64'(jit_a[k].x & 8'hC0), 64'((k % int'(NX)) * int'(STEP)));
      chk($sformatf("jit_cell_y[%0d]", k), 64'(jit_a[k].y & 8'hC0), 64'((k / int'(NX)) * int'(STEP)));
    end
    run_stream(MODE_JITTER, 14'h1abc, 32'h1234_5678, 1'b0, -1, 1'b0);
    jit_b = got;
    diff = 0;
    for (int k = 0; k < int'(NP); k++) if (jit_a[k] !== jit_b[k]) diff++;
    chk("jit_repeat", 64'(diff), 64'd0);

    // Random: seed 0 aliases the default seed, seed 1 differs
    run_stream(MODE_RANDOM, 14'h0001, 32'h0, 1'b0, -1, 1'b0);
    rnd_z = got;
    run_stream(MODE_RANDOM, 14'h0001, 32'hACE1_ACE1, 1'b1, -1, 1'b0);
    rnd_d = got;
    run_stream(MODE_RANDOM, 14'h0001, 32'h1, 1'b0, -1, 1'b0);
    rnd_1 = got;
    diff = 0;
    for (int k = 0; k < int'(NP); k++) if (rnd_z[k] !== rnd_d[k]) diff++;
    chk("seed0_alias", 64'(diff), 64'd0);
    diff = 0;
    for (int k = 0; k < int'(NP); k++) if (rnd_z[k] !== rnd_1[k]) diff++;
    chk("seed1_differs", 64'(diff != 0), 64'd1);

    // Reset in the middle of a run
    build_expected(MODE_GRID, 14'h0333, 32'h0);
    mode = MODE_GRID; mu_init = 14'h0333; seed = 32'h0;
    intf.m_tready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("pre_rst_data[%0d]", k), 64'(intf.m_tdata), 64'(exp_q[k]));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 64'(intf.m_tvalid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    diff = 0;
    for (int c = 0; c < 20; c++) begin
      if (intf.m_tlast !== 1'b0 || intf.m_tvalid !== 1'b0 || done !== 1'b0) diff++;
      @(negedge clk);
    end
    chk("abort_quiet", 64'(diff), 64'd0);
    run_stream(MODE_GRID, 14'h0333, 32'h0, 1'b0, -1, 1'b0);

    // Start during RUN and DONE is ignored; reserved mode behaves as grid
    run_stream(MODE_GRID, 14'h0555, 32'h9, 1'b1, 5, 1'b1);
    run_stream(MODE_RSVD, 14'h0555, 32'h9, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
